// File: rtl/psg_pkg.sv
// psg_pkg: shared constants, types and helpers for the multichannel PSG.
package psg_pkg;

    // Register offsets within a channel's three-byte block
    localparam int unsigned PER_LO = 0;
    localparam int unsigned PER_HI = 1;
    localparam int unsigned CTRL   = 2;

    // Offsets of the shared registers after the last channel block
    localparam int unsigned NOISE_OFS = 0;
    localparam int unsigned PAN_OFS   = 1;

    // Noise LFSR: shift left, new bit0 = q[16] ^ q[13]
    localparam int unsigned     LFSR_W     = 17;
    localparam int unsigned     LFSR_TAP_A = 16;
    localparam int unsigned     LFSR_TAP_B = 13;
    localparam logic [16:0]     LFSR_SEED  = 17'h1;

    // Volume linearisation, index 15 first
    localparam logic [15:0][7:0] LIN_TABLE = {
        8'd255, 8'd128, 8'd90, 8'd64, 8'd45, 8'd32, 8'd22, 8'd16,
        8'd11,  8'd8,   8'd6,  8'd4,  8'd3,  8'd2,  8'd1,  8'd0
    };

    typedef struct packed {
        logic       noise_en;
        logic       tone_en;
        logic [3:0] vol;
    } ch_ctrl_t;

    function automatic logic [7:0] lin(input logic [3:0] vol);
        return LIN_TABLE[vol];
    endfunction

endpackage

// File: rtl/psg_tone_div.sv
// psg_tone_div: period counter with square-wave toggle output. A period written
// below the running count wraps on the next cen instead of counting the long way.
module psg_tone_div #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] period,
    output logic         out
);

    logic [W-1:0] cnt_q;
    logic         out_q;
    logic [W:0]   cnt_inc;
    logic [W-1:0] eff_period;
    logic         wrap;

    // Effective period is at least 1 so period 0 behaves like period 1
    always_comb begin
        eff_period = (period == '0) ? W'(1) : period;
        cnt_inc    = {1'b0, cnt_q} + (W + 1)'(1);
        wrap       = (cnt_inc >= {1'b0, eff_period});
    end

    // Count on each enable, wrap to zero and toggle the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (cen) begin
            if (wrap) begin
                cnt_q <= '0;
                out_q <= ~out_q;
            end else begin
                cnt_q <= cnt_inc[W-1:0];
            end
        end
    end

    assign out = out_q;

endmodule

// File: rtl/psg_multich.sv
// psg_multich: NCH square-wave tone channels plus a shared noise LFSR, mixed by
// a time-multiplexed accumulator into one sample per NCH clk_en pulses.
// Optional: define PSG_STEREO_EN for a pan register and sound_l/sound_r outputs.
module psg_multich #(
    parameter int unsigned NCH = 6,
    parameter int unsigned PW  = 12,
    parameter int unsigned DIV = 16,
    parameter int unsigned AW  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [AW-1:0]              addr,
    input  logic                       cs_n,
    input  logic                       wr_n,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [8+$clog2(NCH)-1:0]   sound,
`ifdef PSG_STEREO_EN
    output logic [8+$clog2(NCH)-1:0]   sound_l,
    output logic [8+$clog2(NCH)-1:0]   sound_r,
`endif
    output logic                       sample
);

    import psg_pkg::*;

    localparam int unsigned SW         = 8 + $clog2(NCH);
    localparam int unsigned PSW        = $clog2(DIV);
    localparam int unsigned NOISE_ADDR = 3 * NCH + NOISE_OFS;

    logic                   wr_en;
    logic [NCH-1:0][PW-1:0] period_q;
    ch_ctrl_t [NCH-1:0]     ctrl_q;
    logic [4:0]             np_q;
    logic [7:0]             rd_data;
    logic [7:0]             dout_q;

    assign wr_en = ~cs_n & ~wr_n;

    // Channel and noise register writes; the bus side ignores clk_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            ctrl_q   <= '0;
            np_q     <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (addr == AW'(3 * i + PER_LO)) period_q[i][7:0]    <= din;
                if (addr == AW'(3 * i + PER_HI)) period_q[i][PW-1:8] <= din[PW-9:0];
                if (addr == AW'(3 * i + CTRL))   ctrl_q[i]           <= ch_ctrl_t'(din[5:0]);
            end
            if (addr == AW'(NOISE_ADDR)) np_q <= din[4:0];
        end
    end

`ifdef PSG_STEREO_EN
    localparam int unsigned PAN_ADDR = 3 * NCH + PAN_OFS;

    logic [NCH-1:0] pan_q;

    // Pan mask: bit i routes channel i to the right accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pan_q <= '0;
        end else if (wr_en && addr == AW'(PAN_ADDR)) begin
            pan_q <= din[NCH-1:0];
        end
    end
`endif

    // Read mux, masked to implemented bits; unmapped addresses read zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (addr == AW'(3 * i + PER_LO)) rd_data = period_q[i][7:0];
            if (addr == AW'(3 * i + PER_HI)) rd_data[PW-9:0] = period_q[i][PW-1:8];
            if (addr == AW'(3 * i + CTRL))   rd_data[5:0] = ctrl_q[i];
        end
        if (addr == AW'(NOISE_ADDR)) rd_data[4:0] = np_q;
`ifdef PSG_STEREO_EN
        if (addr == AW'(PAN_ADDR)) rd_data[NCH-1:0] = pan_q;
`endif
    end

    // Registered read data, one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= rd_data;
    end

    assign dout = dout_q;

    logic [PSW-1:0] pre_q;
    logic           tick;

    assign tick = clk_en & (pre_q == PSW'(DIV - 1));

    // Prescaler over clk_en pulses; DIV is a power of two so it wraps by itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pre_q <= '0;
        else if (clk_en) pre_q <= pre_q + PSW'(1);
    end

    logic [NCH-1:0] tone_bit;

    for (genvar g = 0; g < NCH; g++) begin : g_tone
        psg_tone_div #(
            .W (PW)
        ) u_div (
            .clk    (clk),
            .rst_n  (rst_n),
            .cen    (tick),
            .period (period_q[g]),
            .out    (tone_bit[g])
        );
    end

    logic              noise_tog;
    logic              noise_tog_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic              noise;

    psg_tone_div #(
        .W (5)
    ) u_noise_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (tick),
        .period (np_q),
        .out    (noise_tog)
    );

    // Each toggle of the noise divider marks one wrap and steps the LFSR once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_tog_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else if (clk_en) begin
            noise_tog_q <= noise_tog;
            if (noise_tog != noise_tog_q) begin
                lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
            end
        end
    end

    assign noise = lfsr_q[0];

    logic [NCH-1:0] slot_q;
    logic [NCH-1:0] mix;
    logic [7:0]     term;
    logic           sample_q;
    logic [SW-1:0]  sound_q;

    // Per-channel mix bit and the linearised term of the active slot
    always_comb begin
        mix  = '0;
        term = '0;
        for (int i = 0; i < NCH; i++) begin
            mix[i] = (tone_bit[i] | ~ctrl_q[i].tone_en) & (noise | ~ctrl_q[i].noise_en);
            if (slot_q[i] && mix[i]) term = lin(ctrl_q[i].vol);
        end
    end

`ifdef PSG_STEREO_EN
    logic [SW-1:0] acc_l_q, acc_r_q;
    logic [SW-1:0] sound_l_q, sound_r_q;
    logic [SW-1:0] term_l, term_r;
    logic [SW:0]   lr_sum;

    // Route the active slot's term left or right by its pan bit
    always_comb begin
        term_l = '0;
        term_r = '0;
        if (|(slot_q & pan_q)) term_r = SW'(term);
        else                   term_l = SW'(term);
        lr_sum = {1'b0, acc_l_q} + {1'b0, acc_r_q};
    end

    // Two frame accumulators; slot 0 publishes both sums and the saturated total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= NCH'(1);
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            sound_l_q <= '0;
            sound_r_q <= '0;
            sound_q   <= '0;
            sample_q  <= 1'b0;
        end else begin
            sample_q <= clk_en & slot_q[0];
            if (clk_en) begin
                slot_q <= (slot_q << 1) | NCH'(slot_q[NCH-1]);
                if (slot_q[0]) begin
                    sound_l_q <= acc_l_q;
                    sound_r_q <= acc_r_q;
                    sound_q   <= lr_sum[SW] ? '1 : lr_sum[SW-1:0];
                    acc_l_q   <= term_l;
                    acc_r_q   <= term_r;
                end else begin
                    acc_l_q <= acc_l_q + term_l;
                    acc_r_q <= acc_r_q + term_r;
                end
            end
        end
    end

    assign sound_l = sound_l_q;
    assign sound_r = sound_r_q;
`else
    logic [SW-1:0] acc_q;

    // Frame accumulator; slot 0 publishes the finished sum and restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= NCH'(1);
            acc_q    <= '0;
            sound_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            sample_q <= clk_en & slot_q[0];
            if (clk_en) begin
                slot_q <= (slot_q << 1) | NCH'(slot_q[NCH-1]);
                if (slot_q[0]) begin
                    sound_q <= acc_q;
                    acc_q   <= SW'(term);
                end else begin
                    acc_q <= acc_q + SW'(term);
                end
            end
        end
    end
`endif

    assign sound  = sound_q;
    assign sample = sample_q;

endmodule

// File: doc/psg_multich.md
Name: psg_multich

Overview:
- Parametrised successor of the team's 3-channel PSG: NCH square-wave tone channels, PW-bit periods and one shared noise LFSR.
- Per-channel 4-bit volume is linearised and summed by a time-multiplexed accumulator into one mono sample per frame.
- Sits behind the CPU bus decode; output feeds the board audio mixer.
- No envelope generator; the volume register is static per channel.

Parameters:
- NCH, 6, number of tone channels, 1..8.
- PW, 12, tone period width in bits, 9..16.
- DIV, 16, clk_en pulses per tone/noise tick, power of two, 2..256.
- AW, 5, address width; must satisfy 2^AW >= 3*NCH+2.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  clock enable; all state except the bus interface advances only when high.
- addr  in  AW  register address.
- cs_n  in  1  chip select, active low.
- wr_n  in  1  write strobe, active low.
- din  in  8  write data.
- dout  out  8  registered read data.
- sound  out  8+clog2(NCH)  mono mix, unsigned.
- sample  out  1  one-clk pulse when sound updates.
- sound_l, sound_r  out  8+clog2(NCH)  stereo mix; present only with PSG_STEREO_EN.

Behaviour:
- Register map, channel i:
  - 3i: period[7:0].
  - 3i+1: period[PW-1:8], upper bits ignored.
  - 3i+2: {2'b0, noise_en, tone_en, vol[3:0]}.
- Shared registers:
  - 3*NCH: noise period [4:0].
  - 3*NCH+1: pan mask (bit i = channel i right); exists only with PSG_STEREO_EN, else unmapped.
- Write path:
  - Write = !cs_n & !wr_n, sampled every clk regardless of clk_en.
  - Register updates the cycle after write is seen; held write keeps rewriting.
  - Writes to unmapped addresses are discarded.
- Read path:
  - dout <= reg[addr] masked to implemented bits, every clk, one-cycle latency.
  - Unmapped addresses read 8'h00.
- Tick: prescaler counts clk_en pulses; tick = 1 on the pulse where the count wraps, every DIV pulses.
- Tone channel i:
  - On tick, cnt_i <= cnt_i+1.
  - If cnt_i+1 >= eff_period, then cnt_i <= 0 and bit_i toggles. eff_period = max(period,1).
  - A period write below the current cnt wraps on the next tick; no long count.
- Noise:
  - 5-bit counter using the same >= rule and effective period max(np,1).
  - On wrap, 17-bit LFSR shifts left; new bit0 = q[16]^q[13]. Noise = q[0].
  - LFSR seed 17'h1; the all-zero state is unreachable.
- Mix bit: m_i = (bit_i | ~tone_en_i) & (noise | ~noise_en_i). Both enables 0 gives constant 1 (DC at vol).
- Linearisation (lin, 8 bit, vol 0..15): 0,1,2,3,4,6,8,11,16,22,32,45,64,90,128,255.
- Accumulator:
  - One-hot slot counter over NCH slots, advances on each clk_en.
  - Slot k adds (m_k ? lin(vol_k) : 0) into acc.
  - On slot 0: sound <= acc (final frame sum), acc <= term_0, and sample pulses high for that single clk.
  - Frame length = NCH clk_en pulses.
  - acc width 8+clog2(NCH); no overflow possible (NCH*255 fits).
- Reset:
  - All registers 0, cnt/bit 0, LFSR 17'h1, prescaler 0, slot = 0.
  - acc, sound, sound_l/r, dout, sample all 0.
  - Reset mid-frame discards the partial sum; first sample after release = 0.
- Simultaneous write and tick on the same cycle: the tick uses the old period; the new value applies from the next tick.

Optional Feature:
- Macro: PSG_STEREO_EN.
- Enabled: pan register implemented. Two accumulators: channel term goes to right if pan[i], else left. sound_l/sound_r update on the same sample pulse; sound = sound_l + sound_r, saturated to its width.
- Disabled: no pan register (reads 0), no sound_l/sound_r ports; sound as above.

Decomposition:
- Package psg_pkg: lin table constant, LFSR taps/seed constants, register offset constants (PER_LO, PER_HI, CTRL, NOISE_OFS, PAN_OFS).
- Sub-module psg_tone_div (PW-bit counter and toggle, cen, period, out), instantiated NCH times.
- Noise counter is a PW=5 instance of the same divider.

Test Plan:
- NCH=3, DIV=16, ch0 period 2, tone_en=1, vol 15, others 0 -> bit_0 toggles every 32 clk_en pulses; sound alternates 0 and 255 in half-periods of 32 pulses.
- Period 0 vs 1 on ch1 -> identical waveforms (toggle every tick).
- Ch0 period 100, wait until cnt=50, write period 10 -> toggle at the next tick, then every 10 ticks.
- All 3 channels DC (enables 0), vol 15,12,8 -> sound = 255+64+16 = 335 after one full frame; sample pulses once per 3 clk_en.
- Noise period 1, ch2 noise_en only -> first 5 LFSR outputs from seed 1 match the golden model; read addr 3*NCH returns only bits [4:0].
- rst_n low mid-frame with sound=335 -> sound=0, dout=0, regs 0 immediately; first post-reset sample = 0. Stereo build: pan=3'b010, DC vols -> sound_r=lin(vol1), sound_l=rest.
